cd_sector_streamer: RTL and testbench



---
 rtl/cd_sector_streamer.sv | 205 ++++++++++++++++++++
 tb/tb_cd_sector_streamer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cd_sector_streamer.sv
// cd_sector_streamer
//   Turns a CD sector request (LBA + request edge) into an HPS block read,
//   buffers the incoming 16-bit words in a small show-ahead FIFO, and replays
//   exactly SECTOR_WORDS paced word strobes toward the CDIC. Missing words are
//   padded with 0x0000; with no image mounted an all-zero sector is produced.
//
// Ports
//   clk30, reset                : system clock, async active-high reset
//   cd_hps_lba, cd_hps_req      : sector request (LBA captured on req rising edge)
//   cd_img_mounted              : image present
//   cd_hps_ack                  : one-cycle pulse when sector delivery starts
//   cd_hps_data_valid/_data     : paced output word strobe and word
//   hps_lba, hps_rd             : block read request toward HPS
//   hps_ack, hps_wr, hps_din    : HPS transfer window, word strobe, word
//   busy                        : state machine not idle
//   err_overflow/short/timeout  : sticky error flags
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request edge or a pending request
// REQ   | hps_rd raised, waiting for hps_ack (with timeout)
// XFER  | HPS words arriving into the FIFO, output already streaming
// DRAIN | HPS finished; flush FIFO then pad with zeros to a full sector
// ZERO  | no image or timeout: emit a sector of zeros
module cd_sector_streamer #(
  parameter int SECTOR_WORDS = 1176,
  parameter int FIFO_DEPTH   = 64,
  parameter int PACE         = 2,
  parameter int ACK_TIMEOUT  = 65535
) (
  input  logic        clk30,
  input  logic        reset,
  input  logic [31:0] cd_hps_lba,
  input  logic        cd_hps_req,
  input  logic        cd_img_mounted,
  output logic        cd_hps_ack,
  output logic        cd_hps_data_valid,
  output logic [15:0] cd_hps_data,
  output logic [31:0] hps_lba,
  output logic        hps_rd,
  input  logic        hps_ack,
  input  logic        hps_wr,
  input  logic [15:0] hps_din,
  output logic        busy,
  output logic        err_overflow,
  output logic        err_short,
  output logic        err_timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (PACE > 1) ? $clog2(PACE) : 1;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [10:0] SW = 11'(SECTOR_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_XFER, S_DRAIN, S_ZERO} state_t;
  state_t state, state_nxt;

  logic          req_d, req_edge;
  logic [31:0]   req_lba;
  logic          pend_valid;
  logic [31:0]   pend_lba;
  logic [TW-1:0] tmo_cnt;
  logic [PW-1:0] pace_cnt;
  logic [10:0]   in_cnt, out_cnt;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full;

  logic start, ack_ok, tmo_hit, short_set, word_avail, strobe;
  logic push_req, push, pop, drop;
  logic [31:0] start_lba;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign start_lba  = req_edge ? req_lba : pend_lba;

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    ack_ok     = 1'b0;
    tmo_hit    = 1'b0;
    short_set  = 1'b0;
    word_avail = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_edge || pend_valid) begin
          start     = 1'b1;
          state_nxt = cd_img_mounted ? S_REQ : S_ZERO;
        end
      end
      S_REQ: begin
        if (hps_ack) begin
          ack_ok    = 1'b1;
          state_nxt = S_XFER;
        end else if (tmo_cnt == '0) begin
          tmo_hit   = 1'b1;
          state_nxt = S_ZERO;
        end
      end
      S_XFER: begin
        word_avail = !fifo_empty;
        if (!hps_ack) begin
          state_nxt = S_DRAIN;
          short_set = (in_cnt < SW);
        end
      end
      S_DRAIN: begin
        word_avail = 1'b1;
        if (out_cnt == SW) state_nxt = S_IDLE;
      end
      S_ZERO: begin
        word_avail = 1'b1;
        if (out_cnt == SW) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    strobe = word_avail && (pace_cnt == '0) && (out_cnt < SW);
    // Leave on the final strobe itself so busy drops the very next cycle.
    if (strobe && (out_cnt == SW - 11'd1) && (state == S_DRAIN || state == S_ZERO))
      state_nxt = S_IDLE;
  end

  // Pop frees a slot in the same cycle, so a push on a full FIFO still lands.
  assign pop      = strobe && !fifo_empty;
  assign push_req = (state == S_XFER) && hps_ack && hps_wr && (in_cnt < SW);
  assign push     = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;

  assign cd_hps_data_valid = strobe;
  assign cd_hps_data       = pop ? mem[rd_ptr[AW-1:0]] : 16'h0000;
  assign busy              = (state != S_IDLE);

  always_ff @(posedge clk30 or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      req_d        <= 1'b0;
      req_edge     <= 1'b0;
      req_lba      <= '0;
      pend_valid   <= 1'b0;
      pend_lba     <= '0;
      tmo_cnt      <= '0;
      pace_cnt     <= '0;
      in_cnt       <= '0;
      out_cnt      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      hps_lba      <= '0;
      hps_rd       <= 1'b0;
      cd_hps_ack   <= 1'b0;
      err_overflow <= 1'b0;
      err_short    <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      req_d    <= cd_hps_req;
      req_edge <= cd_hps_req && !req_d;
      if (cd_hps_req && !req_d) req_lba <= cd_hps_lba;

      if (req_edge && state != S_IDLE) begin
        pend_valid <= 1'b1;
        pend_lba   <= req_lba;
      end else if (start) begin
        pend_valid <= 1'b0;
      end

      if (start && cd_img_mounted) begin
        hps_lba <= start_lba;
        hps_rd  <= 1'b1;
      end else if (ack_ok || tmo_hit) begin
        hps_rd  <= 1'b0;
      end
      cd_hps_ack <= ack_ok || tmo_hit || (start && !cd_img_mounted);

      if (start) tmo_cnt <= TW'(ACK_TIMEOUT - 1);
      else if (state == S_REQ && tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;

      // Entering ZERO holds off one cycle so the first zero word follows the ack pulse.
      if ((start && !cd_img_mounted) || tmo_hit) pace_cnt <= PW'(1);
      else if (start || ack_ok)                  pace_cnt <= '0;
      else if (strobe)                           pace_cnt <= PW'(PACE - 1);
      else if (pace_cnt != '0)                   pace_cnt <= pace_cnt - 1'b1;

      if (start || ack_ok) begin
        in_cnt  <= '0;
        out_cnt <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
      end else begin
        if (push_req) in_cnt  <= in_cnt + 11'd1;
        if (strobe)   out_cnt <= out_cnt + 11'd1;
        if (push)     wr_ptr  <= wr_ptr + 1'b1;
        if (pop)      rd_ptr  <= rd_ptr + 1'b1;
      end

      if (drop)      err_overflow <= 1'b1;
      if (short_set) err_short    <= 1'b1;
      if (tmo_hit)   err_timeout  <= 1'b1;
    end
  end

  always_ff @(posedge clk30) begin
    if (push) mem[wr_ptr[AW-1:0]] <= hps_din;
  end

endmodule

// File: tb/tb_cd_sector_streamer.sv
module tb_cd_sector_streamer;
  logic        clk30 = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] lba = '0;
  logic        req = 1'b0, req8 = 1'b0, mounted = 1'b1;
  logic        hack = 1'b0, hwr = 1'b0;
  logic [15:0] hdin = '0;

  logic        ack_a, dv_a, rd_a, busy_a, ovf_a, short_a, tmo_a;
  logic [15:0] data_a;
  logic [31:0] hlba_a;
  logic        ack_b, dv_b, rd_b, busy_b, ovf_b, short_b, tmo_b;
  logic [15:0] data_b;
  logic [31:0] hlba_b;

  always #5 clk30 = ~clk30;

  cd_sector_streamer #(.SECTOR_WORDS(1176), .FIFO_DEPTH(64), .PACE(2), .ACK_TIMEOUT(100)) dut (
    .clk30(clk30), .reset(reset), .cd_hps_lba(lba), .cd_hps_req(req), .cd_img_mounted(mounted),
    .cd_hps_ack(ack_a), .cd_hps_data_valid(dv_a), .cd_hps_data(data_a),
    .hps_lba(hlba_a), .hps_rd(rd_a), .hps_ack(hack), .hps_wr(hwr), .hps_din(hdin),
    .busy(busy_a), .err_overflow(ovf_a), .err_short(short_a), .err_timeout(tmo_a));

  cd_sector_streamer #(.SECTOR_WORDS(1176), .FIFO_DEPTH(64), .PACE(8), .ACK_TIMEOUT(100)) dut8 (
    .clk30(clk30), .reset(reset), .cd_hps_lba(lba), .cd_hps_req(req8), .cd_img_mounted(mounted),
    .cd_hps_ack(ack_b), .cd_hps_data_valid(dv_b), .cd_hps_data(data_b),
    .hps_lba(hlba_b), .hps_rd(rd_b), .hps_ack(hack), .hps_wr(hwr), .hps_din(hdin),
    .busy(busy_b), .err_overflow(ovf_b), .err_short(short_b), .err_timeout(tmo_b));

  logic        sel = 1'b0;
  logic        m_dv, m_ack, m_rd, m_busy;
  logic [15:0] m_data;
  assign m_dv   = sel ? dv_b   : dv_a;
  assign m_ack  = sel ? ack_b  : ack_a;
  assign m_rd   = sel ? rd_b   : rd_a;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_data = sel ? data_b : data_a;

  logic [15:0] cap [0:2047];
  int scnt = 0, ackcnt = 0;
  bit rd_seen = 0;
  int total = 0, bad = 0;

  always @(negedge clk30) begin
    if (m_dv) begin
      if (scnt < 2048) cap[scnt] = m_data;
      scnt++;
    end
    if (m_ack) ackcnt++;
    if (m_rd) rd_seen = 1;
  end

  task automatic do_reset();
    @(posedge clk30); #1;
    reset = 1; req = 0; req8 = 0; hack = 0; hwr = 0;
    repeat (2) @(posedge clk30);
    #1 reset = 0;
    scnt = 0; ackcnt = 0; rd_seen = 0;
  endtask

  task automatic issue_req(input logic [31:0] l);
    @(posedge clk30); #1;
    lba = l;
    if (sel) req8 = 1; else req = 1;
    @(posedge clk30); #1;
    req = 0; req8 = 0;
  endtask

  task automatic send_words(input int n, input int gap, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      @(posedge clk30); #1;
      hwr = 1; hdin = base + 16'(i);
      repeat (gap) begin
        @(posedge clk30); #1 hwr = 0;
      end
    end
    @(posedge clk30); #1 hwr = 0;
  endtask

  task automatic wait_rd(input int bound, input string nm);
    for (int i = 0; i < bound && !m_rd; i++) @(negedge clk30);
    total++;
    if (!m_rd) begin bad++; $display("FAIL %s: hps_rd=%0b required 1 within %0d cycles", nm, m_rd, bound); end
  endtask

  task automatic wait_idle(input int bound, input string nm);
    for (int i = 0; i < bound && m_busy; i++) @(negedge clk30);
    total++;
    if (m_busy) begin bad++; $display("FAIL %s: busy=%0b required 0 within %0d cycles", nm, m_busy, bound); end
    @(posedge clk30); #1;
  endtask

  task automatic hps_serve(input int n, input int gap, input logic [15:0] base);
    wait_rd(200, "serve_rd");
    repeat (10) @(posedge clk30);
    #1 hack = 1;
    send_words(n, gap, base);
    repeat (3) @(posedge clk30);
    #1 hack = 0;
  endtask

  task automatic check_ramp(input int n, input string nm);
    int errs, first;
    errs = 0; first = -1;
    for (int i = 0; i < 1176; i++) begin
      if (cap[i] !== ((i < n) ? 16'(i) : 16'h0000)) begin
        errs++;
        if (first < 0) first = i;
      end
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL %s: %0d wrong words, first at %0d (got %h) required ramp to %0d then zeros", nm, errs, first, cap[first], n); end
  endtask

  task automatic test_reset();
    #2;
    total++; if (ack_a !== 1'b0)    begin bad++; $display("FAIL rst_ack: got %b required 0", ack_a); end
    total++; if (dv_a !== 1'b0)     begin bad++; $display("FAIL rst_valid: got %b required 0", dv_a); end
    total++; if (data_a !== 16'h0)  begin bad++; $display("FAIL rst_data: got %h required 0000", data_a); end
    total++; if (hlba_a !== 32'h0)  begin bad++; $display("FAIL rst_hps_lba: got %h required 0", hlba_a); end
    total++; if (rd_a !== 1'b0)     begin bad++; $display("FAIL rst_hps_rd: got %b required 0", rd_a); end
    total++; if (busy_a !== 1'b0)   begin bad++; $display("FAIL rst_busy: got %b required 0", busy_a); end
    total++; if ({ovf_a, short_a, tmo_a} !== 3'b000) begin bad++; $display("FAIL rst_flags: got %b required 000", {ovf_a, short_a, tmo_a}); end
    do_reset();
  endtask

  task automatic test_normal();
    sel = 0; mounted = 1;
    issue_req(32'h1234);
    @(negedge clk30);
    total++; if (rd_a !== 1'b0) begin bad++; $display("FAIL rd_early: got %b required 0", rd_a); end
    @(negedge clk30);
    total++; if (rd_a !== 1'b1) begin bad++; $display("FAIL rd_n2: got %b required 1", rd_a); end
    total++; if (hlba_a !== 32'h1234) begin bad++; $display("FAIL normal_lba: got %h required 00001234", hlba_a); end
    repeat (10) @(posedge clk30);
    #1 hack = 1;
    @(posedge clk30);
    @(negedge clk30);
    total++; if ({ack_a, rd_a} !== 2'b10) begin bad++; $display("FAIL ack_m1: ack,rd got %b required 10", {ack_a, rd_a}); end
    @(negedge clk30);
    total++; if (ack_a !== 1'b0) begin bad++; $display("FAIL ack_pulse: got %b required 0", ack_a); end
    @(posedge clk30); #1 hwr = 1; hdin = 16'd0;
    @(posedge clk30); #1 hwr = 0;
    @(negedge clk30);
    total++; if ({dv_a, data_a} !== 17'h0_0000 + 17'h1_0000) begin bad++; $display("FAIL show_ahead: valid,data got %b,%h required 1,0000", dv_a, data_a); end
    repeat (2) @(posedge clk30);
    send_words(1175, 3, 16'd1);
    repeat (3) @(posedge clk30);
    #1 hack = 0;
    wait_idle(3000, "normal_idle");
    total++; if (scnt !== 1176) begin bad++; $display("FAIL normal_count: got %0d required 1176", scnt); end
    check_ramp(1176, "normal_data");
    total++; if (ackcnt !== 1) begin bad++; $display("FAIL normal_ackcnt: got %0d required 1", ackcnt); end
    total++; if ({ovf_a, short_a, tmo_a} !== 3'b000) begin bad++; $display("FAIL normal_flags: got %b required 000", {ovf_a, short_a, tmo_a}); end
  endtask

  task automatic test_no_image();
    int nz;
    do_reset();
    sel = 0; mounted = 0;
    issue_req(32'h5);
    @(negedge clk30);
    total++; if (ack_a !== 1'b0) begin bad++; $display("FAIL zero_ack_early: got %b required 0", ack_a); end
    @(negedge clk30);
    total++; if ({ack_a, dv_a} !== 2'b10) begin bad++; $display("FAIL zero_ack: ack,valid got %b required 10", {ack_a, dv_a}); end
    @(negedge clk30);
    total++; if ({ack_a, dv_a} !== 2'b01) begin bad++; $display("FAIL zero_first_strobe: ack,valid got %b required 01", {ack_a, dv_a}); end
    wait_idle(5000, "zero_idle");
    nz = 0;
    for (int i = 0; i < 1176; i++) if (cap[i] !== 16'h0) nz++;
    total++; if (scnt !== 1176) begin bad++; $display("FAIL zero_count: got %0d required 1176", scnt); end
    total++; if (nz !== 0) begin bad++; $display("FAIL zero_data: %0d nonzero words required 0", nz); end
    total++; if (ackcnt !== 1) begin bad++; $display("FAIL zero_ackcnt: got %0d required 1", ackcnt); end
    total++; if (rd_seen !== 1'b0) begin bad++; $display("FAIL zero_rd: hps_rd seen %b required 0", rd_seen); end
    mounted = 1;
  endtask

  task automatic test_overflow();
    int last, viol, nz;
    bit zero_seen;
    do_reset();
    sel = 1; mounted = 1;
    issue_req(32'hABC);
    hps_serve(1176, 0, 16'd1);
    wait_idle(20000, "ovf_idle");
    last = 0; viol = 0; nz = 0; zero_seen = 0;
    for (int i = 0; i < 1176; i++) begin
      if (cap[i] === 16'h0) zero_seen = 1;
      else begin
        if (zero_seen || int'(cap[i]) <= last) viol++;
        last = int'(cap[i]);
        nz++;
      end
    end
    total++; if (ovf_b !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b required 1", ovf_b); end
    total++; if (hlba_b !== 32'hABC) begin bad++; $display("FAIL ovf_lba: got %h required 00000abc", hlba_b); end
    total++; if (scnt !== 1176) begin bad++; $display("FAIL ovf_count: got %0d required 1176", scnt); end
    total++; if (cap[0] !== 16'd1) begin bad++; $display("FAIL ovf_first: got %h required 0001", cap[0]); end
    total++; if (viol !== 0) begin bad++; $display("FAIL ovf_order: %0d out-of-order words required 0", viol); end
    total++; if (cap[1175] !== 16'h0) begin bad++; $display("FAIL ovf_tail: got %h required 0000 (%0d real words)", cap[1175], nz); end
    total++; if (short_b !== 1'b0) begin bad++; $display("FAIL ovf_short: got %b required 0", short_b); end
    sel = 0;
  endtask

  task automatic test_short();
    do_reset();
    sel = 0;
    issue_req(32'h20);
    hps_serve(1000, 3, 16'd0);
    wait_idle(3000, "short_idle");
    total++; if (scnt !== 1176) begin bad++; $display("FAIL short_count: got %0d required 1176", scnt); end
    check_ramp(1000, "short_data");
    total++; if ({ovf_a, short_a, tmo_a} !== 3'b010) begin bad++; $display("FAIL short_flags: got %b required 010", {ovf_a, short_a, tmo_a}); end
  endtask

  task automatic test_timeout_pending();
    int nz;
    do_reset();
    sel = 0;
    issue_req(32'h55);
    @(negedge clk30); @(negedge clk30);
    total++; if (hlba_a !== 32'h55) begin bad++; $display("FAIL tmo_lba1: got %h required 00000055", hlba_a); end
    repeat (5) @(posedge clk30);
    issue_req(32'h7);
    for (int i = 0; i < 300 && !tmo_a; i++) @(negedge clk30);
    total++; if (tmo_a !== 1'b1) begin bad++; $display("FAIL tmo_flag: got %b required 1", tmo_a); end
    total++; if (rd_a !== 1'b0) begin bad++; $display("FAIL tmo_rd: got %b required 0", rd_a); end
    @(negedge clk30); @(negedge clk30);
    total++; if (ackcnt !== 1) begin bad++; $display("FAIL tmo_ackcnt: got %0d required 1", ackcnt); end
    wait_rd(5000, "pend_rd");
    nz = 0;
    for (int i = 0; i < 1176; i++) if (cap[i] !== 16'h0) nz++;
    total++; if (scnt !== 1176 || nz !== 0) begin bad++; $display("FAIL tmo_zero_sector: count %0d nonzero %0d required 1176 and 0", scnt, nz); end
    total++; if (hlba_a !== 32'h7) begin bad++; $display("FAIL pend_lba: got %h required 00000007", hlba_a); end
  endtask

  task automatic test_reset_mid();
    int s0;
    do_reset();
    sel = 0;
    issue_req(32'h300);
    wait_rd(200, "mid_rd");
    repeat (10) @(posedge clk30);
    #1 hack = 1;
    for (int i = 0; i < 1176 && scnt < 300; i++) begin
      @(posedge clk30); #1;
      hwr = 1; hdin = 16'(i);
      repeat (3) begin @(posedge clk30); #1 hwr = 0; end
    end
    total++; if (scnt !== 300) begin bad++; $display("FAIL mid_pre: got %0d strobes required 300", scnt); end
    @(posedge clk30); #1 reset = 1;
    #1;
    total++; if ({dv_a, busy_a, rd_a, ack_a} !== 4'b0000 || data_a !== 16'h0) begin bad++; $display("FAIL mid_reset_out: valid,busy,rd,ack got %b data %h required 0000 0000", {dv_a, busy_a, rd_a, ack_a}, data_a); end
    @(posedge clk30); #1 reset = 0;
    s0 = scnt;
    send_words(20, 3, 16'h0AAA);
    total++; if (scnt !== s0 || busy_a !== 1'b0) begin bad++; $display("FAIL mid_ignore: strobes %0d busy %b required %0d and 0", scnt, busy_a, s0); end
    #1 hack = 0;
    scnt = 0; ackcnt = 0;
    issue_req(32'h99);
    hps_serve(1176, 3, 16'd0);
    wait_idle(3000, "mid_idle");
    total++; if (scnt !== 1176) begin bad++; $display("FAIL mid_after_count: got %0d required 1176", scnt); end
    check_ramp(1176, "mid_after_data");
  endtask

  initial begin
    test_reset();
    test_normal();
    test_no_image();
    test_overflow();
    test_short();
    test_timeout_pending();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
